// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong reorder buffer placed after a pipelined FFT core.
// Frames arrive in bit-reversed order and leave in natural order on an
// FFT-style result interface (dv, xk_re/xk_im, xk_index, edone, done).
// Frame size (log2) is programmable per frame, from 8 points up to 2^MAX_LOG2N.
// Optional build macro: FFT_REORDER_DROP_CNT_EN enables the saturating counter
// of in_dv cycles rejected while rfd is low; otherwise drop_cnt is tied to 0.
module fft_bitrev_reorder #(
    parameter int DATA_W    = 16,
    parameter int MAX_LOG2N = 12,
    parameter int NW        = $clog2(MAX_LOG2N + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NW-1:0]        nfft,
    input  logic                 nfft_we,
    input  logic                 in_dv,
    input  logic [DATA_W-1:0]    in_re,
    input  logic [DATA_W-1:0]    in_im,
    output logic                 rfd,
    output logic                 busy,
    output logic                 dv,
    output logic [DATA_W-1:0]    xk_re,
    output logic [DATA_W-1:0]    xk_im,
    output logic [MAX_LOG2N-1:0] xk_index,
    output logic                 edone,
    output logic                 done,
    output logic [15:0]          drop_cnt
);

    localparam int DEPTH = 2 ** MAX_LOG2N;
    localparam int NTAB  = 2 ** NW;

    typedef enum logic {R_IDLE, R_RUN} rstate_t;

    // Frame-size bookkeeping: shadow (host view), latched write size, per-bank size
    logic [NW-1:0]        r_nfft_shadow;
    logic [NW-1:0]        r_wlog2;
    logic [NW-1:0]        r_rlog2;
    logic [NW-1:0]        r_bank_log2 [2];

    // Write side
    logic [1:0]           r_full;
    logic                 r_wbank;
    logic [MAX_LOG2N-1:0] r_wcnt;

    // Read side
    rstate_t              r_state;
    logic                 r_rbank;
    logic                 r_obank;
    logic [MAX_LOG2N-1:0] r_raddr;
    logic [MAX_LOG2N-1:0] r_idx;
    logic                 r_dv;
    logic                 r_done;
    logic                 r_edone;

    // Per-size lookup: last index of a frame and bit-reversed write address
    logic [NTAB-1:0][MAX_LOG2N-1:0] w_mask_tab;
    logic [NTAB-1:0][MAX_LOG2N-1:0] w_rev_tab;

    logic [NW-1:0]        w_cur_log2;
    logic [MAX_LOG2N-1:0] w_wr_mask;
    logic [MAX_LOG2N-1:0] w_waddr;
    logic                 w_rfd;
    logic                 w_accept;
    logic                 w_wr_last;
    logic                 w_rd_start;
    logic                 w_rd_act;
    logic [MAX_LOG2N-1:0] w_rd_addr;
    logic [NW-1:0]        w_rd_l;
    logic [MAX_LOG2N-1:0] w_rd_mask;
    logic                 w_rd_last;
    logic                 w_rd_elast;
    logic [2*DATA_W-1:0]  w_rd_data [2];

    genvar gi, gj;

    // Only sizes 3..MAX_LOG2N are reachable because the shadow register clamps.
    generate
        for (gi = 0; gi < NTAB; gi++) begin : g_tab
            if (gi >= 3 && gi <= MAX_LOG2N) begin : g_valid
                assign w_mask_tab[gi] = MAX_LOG2N'((1 << gi) - 1);
                for (gj = 0; gj < MAX_LOG2N; gj++) begin : g_bit
                    if (gj < gi) begin : g_rev
                        assign w_rev_tab[gi][gj] = r_wcnt[gi-1-gj];
                    end else begin : g_zero
                        assign w_rev_tab[gi][gj] = 1'b0;
                    end
                end
            end else begin : g_unused
                assign w_mask_tab[gi] = '0;
                assign w_rev_tab[gi]  = '0;
            end
        end
    endgenerate

    // A new size only takes effect at a frame boundary (write count 0).
    assign w_cur_log2 = (r_wcnt == '0) ? r_nfft_shadow : r_wlog2;
    assign w_wr_mask  = w_mask_tab[w_cur_log2];
    assign w_waddr    = w_rev_tab[w_cur_log2];
    assign w_rfd      = ~r_full[r_wbank];
    assign w_accept   = in_dv & w_rfd;
    assign w_wr_last  = (r_wcnt == w_wr_mask);

    // The read of address 0 is issued straight from idle so that a full bank
    // starts draining the cycle after its last write.
    assign w_rd_start = (r_state == R_IDLE) && r_full[r_rbank];
    assign w_rd_act   = w_rd_start || (r_state == R_RUN);
    assign w_rd_addr  = (r_state == R_RUN) ? r_raddr : '0;
    assign w_rd_l     = (r_state == R_RUN) ? r_rlog2 : r_bank_log2[r_rbank];
    assign w_rd_mask  = w_mask_tab[w_rd_l];
    assign w_rd_last  = w_rd_act && (w_rd_addr == w_rd_mask);
    assign w_rd_elast = w_rd_act && (w_rd_addr == (w_rd_mask - MAX_LOG2N'(1)));

    // Shadow frame size, clamped to the supported range on every write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nfft_shadow <= NW'(MAX_LOG2N);
        end else if (nfft_we) begin
            if (nfft < NW'(3))
                r_nfft_shadow <= NW'(3);
            else if (nfft > NW'(MAX_LOG2N))
                r_nfft_shadow <= NW'(MAX_LOG2N);
            else
                r_nfft_shadow <= nfft;
        end
    end

    // Bank control: write counter/bank flags plus the two-state read FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt         <= '0;
            r_wlog2        <= NW'(MAX_LOG2N);
            r_wbank        <= 1'b0;
            r_full         <= 2'b00;
            r_bank_log2[0] <= NW'(MAX_LOG2N);
            r_bank_log2[1] <= NW'(MAX_LOG2N);
            r_state        <= R_IDLE;
            r_rbank        <= 1'b0;
            r_obank        <= 1'b0;
            r_raddr        <= '0;
            r_rlog2        <= NW'(MAX_LOG2N);
            r_idx          <= '0;
            r_dv           <= 1'b0;
            r_done         <= 1'b0;
            r_edone        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wlog2 <= w_cur_log2;
                if (w_wr_last) begin
                    r_wcnt               <= '0;
                    r_full[r_wbank]      <= 1'b1;
                    r_bank_log2[r_wbank] <= w_cur_log2;
                    r_wbank              <= ~r_wbank;
                end else begin
                    r_wcnt <= r_wcnt + MAX_LOG2N'(1);
                end
            end

            // Outputs lag the issued address by the one-cycle RAM read
            r_dv    <= w_rd_act;
            r_done  <= w_rd_last;
            r_edone <= w_rd_elast;
            r_obank <= r_rbank;
            if (w_rd_act)
                r_idx <= w_rd_addr;

            case (r_state)
                R_IDLE: begin
                    if (w_rd_start) begin
                        r_rlog2 <= r_bank_log2[r_rbank];
                        r_raddr <= MAX_LOG2N'(1);
                        r_state <= R_RUN;
                    end
                end
                R_RUN: begin
                    if (w_rd_last) begin
                        // The writer never owns a full bank, so this clear
                        // cannot collide with a same-cycle set above.
                        r_full[r_rbank] <= 1'b0;
                        r_rbank         <= ~r_rbank;
                        if (r_full[~r_rbank]) begin
                            r_raddr <= '0;
                            r_rlog2 <= r_bank_log2[~r_rbank];
                        end else begin
                            r_state <= R_IDLE;
                        end
                    end else begin
                        r_raddr <= r_raddr + MAX_LOG2N'(1);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Two simple dual-port banks; write port on the write side, registered read
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [2*DATA_W-1:0] r_mem [DEPTH];
            logic [2*DATA_W-1:0] r_rd;

            // Synchronous write of the incoming sample at its bit-reversed slot
            always_ff @(posedge clk) begin
                if (w_accept && (r_wbank == 1'(gi)))
                    r_mem[w_waddr] <= {in_re, in_im};
            end

            // Registered read; the output register clears on reset
            always_ff @(posedge clk) begin
                if (rst)
                    r_rd <= '0;
                else
                    r_rd <= r_mem[w_rd_addr];
            end

            assign w_rd_data[gi] = r_rd;
        end
    endgenerate

`ifdef FFT_REORDER_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    // Saturating count of input cycles offered while the buffer was full
    always_ff @(posedge clk) begin
        if (rst)
            r_drop_cnt <= '0;
        else if (in_dv && !w_rfd && (r_drop_cnt != 16'hFFFF))
            r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

    assign rfd            = w_rfd;
    assign busy           = w_rd_act | r_dv;
    assign dv             = r_dv;
    assign done           = r_done;
    assign edone          = r_edone;
    assign xk_index       = r_idx;
    assign {xk_re, xk_im} = w_rd_data[r_obank];

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Testbench for fft_bitrev_reorder: table-driven first frame, then random
// frames scored against a queue of natural-order expectations built from
// the bit-reversal definition. Honors FFT_REORDER_DROP_CNT_EN for drop_cnt.
module tb_fft_bitrev_reorder;

    localparam int DATA_W    = 16;
    localparam int MAX_LOG2N = 12;
    localparam int NW        = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NW-1:0]        nfft;
    logic                 nfft_we;
    logic                 in_dv;
    logic [DATA_W-1:0]    in_re;
    logic [DATA_W-1:0]    in_im;
    logic                 rfd;
    logic                 busy;
    logic                 dv;
    logic [DATA_W-1:0]    xk_re;
    logic [DATA_W-1:0]    xk_im;
    logic [MAX_LOG2N-1:0] xk_index;
    logic                 edone;
    logic                 done;
    logic [15:0]          drop_cnt;

    fft_bitrev_reorder #(.DATA_W(DATA_W), .MAX_LOG2N(MAX_LOG2N)) dut (
        .clk(clk), .rst(rst), .nfft(nfft), .nfft_we(nfft_we),
        .in_dv(in_dv), .in_re(in_re), .in_im(in_im),
        .rfd(rfd), .busy(busy), .dv(dv), .xk_re(xk_re), .xk_im(xk_im),
        .xk_index(xk_index), .edone(edone), .done(done), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [11:0] idx;
        logic        edone;
        logic        done;
    } exp_t;

    typedef struct packed {
        logic [15:0] re_in;
        logic [15:0] im_in;
        logic [15:0] exp_re;
        logic [11:0] exp_idx;
    } vec_t;

    exp_t        sb[$];
    vec_t        vtab [8];
    logic [31:0] fr [4096];

    int errors       = 0;
    int checks       = 0;
    int cyc          = 0;
    int first_dv_cyc = 0;
    int rise_cnt     = 0;
    int done_cnt     = 0;
    int last_acc_cyc = 0;
    int stall_total  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bitrev(int k, int l);
        int r = 0;
        for (int i = 0; i < l; i++)
            if (((k >> i) & 1) != 0) r = r | (1 << (l - 1 - i));
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Output monitor: every dv cycle is compared against the scoreboard head
    task automatic monitor_loop();
        logic prev_dv = 1'b0;
        exp_t e;
        int   n_in_frame = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (dv && !prev_dv) begin
                    first_dv_cyc = cyc;
                    rise_cnt++;
                end
                if (dv) begin
                    checks++;
                    n_in_frame++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL out_extra: dv=1 idx=%0d re=%0h with nothing expected", xk_index, xk_re);
                    end else begin
                        e = sb.pop_front();
                        if ({xk_re, xk_im, xk_index, edone, done} !== e || busy !== 1'b1) begin
                            errors++;
                            $display("FAIL out_sample: got re=%0h im=%0h idx=%0d edone=%b done=%b busy=%b, expected re=%0h im=%0h idx=%0d edone=%b done=%b busy=1",
                                     xk_re, xk_im, xk_index, edone, done, busy, e.re, e.im, e.idx, e.edone, e.done);
                        end
                    end
                    if (done) begin
                        done_cnt++;
                        $display("frame out: %0d samples, last idx=%0d at cycle %0d", n_in_frame, xk_index, cyc);
                        n_in_frame = 0;
                    end
                end else if (done || edone) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_no_dv: done=%b edone=%b, expected 0 while dv=0", done, edone);
                end
            end else begin
                n_in_frame = 0;
            end
            prev_dv = dv;
        end
    endtask

    // Offer one sample, waiting (bounded) for rfd; counts stall cycles
    task automatic send(logic [15:0] re, logic [15:0] im);
        int guard = 0;
        in_re = re;
        in_im = im;
        in_dv = 1'b1;
        while (!rfd && guard < 10000) begin
            stall_total++;
            guard++;
            @(posedge clk); #1;
        end
        if (guard >= 10000) chk("rfd_timeout", 32'(rfd), 32'd1);
        @(posedge clk); #1;
        last_acc_cyc = cyc;
    endtask

    // Drive one frame of 2^l samples; optionally pulse nfft_we at sample we_at
    task automatic send_frame(int l, int we_at, logic [NW-1:0] we_val, int mode);
        int   n = 1 << l;
        exp_t e;
        for (int k = 0; k < n; k++) begin
            if (mode == 1 && (k % 2) == 1) fr[k] = {16'h8000, 16'h7FFF};
            else                           fr[k] = $urandom;
        end
        for (int x = 0; x < n; x++) begin
            e.re    = fr[bitrev(x, l)][31:16];
            e.im    = fr[bitrev(x, l)][15:0];
            e.idx   = 12'(x);
            e.edone = (x == n - 2);
            e.done  = (x == n - 1);
            sb.push_back(e);
        end
        for (int k = 0; k < n; k++) begin
            if (k == we_at) begin
                nfft    = we_val;
                nfft_we = 1'b1;
            end
            send(fr[k][31:16], fr[k][15:0]);
            nfft_we = 1'b0;
        end
        in_dv = 1'b0;
        $display("frame in: %0d samples, last accepted at cycle %0d", n, last_acc_cyc);
    endtask

    task automatic set_nfft(logic [NW-1:0] v);
        nfft    = v;
        nfft_we = 1'b1;
        @(posedge clk); #1;
        nfft_we = 1'b0;
    endtask

    task automatic wait_drain(string name);
        int g = 0;
        while (sb.size() != 0 && g < 10000) begin
            @(posedge clk); #1;
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_rfd"},      32'(rfd),      32'd1);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_dv"},       32'(dv),       32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_edone"},    32'(edone),    32'd0);
        chk({tag, "_xk_re"},    32'(xk_re),    32'd0);
        chk({tag, "_xk_im"},    32'(xk_im),    32'd0);
        chk({tag, "_xk_index"}, 32'(xk_index), 32'd0);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   s0, r0, d0, exp_drop;
        int   brv [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        exp_t e;

        rst = 1'b1; nfft = '0; nfft_we = 1'b0; in_dv = 1'b0; in_re = '0; in_im = '0;
        fork monitor_loop(); join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven 8-point frame: inputs are the bit-reversed indices
        for (int i = 0; i < 8; i++) begin
            vtab[i].re_in   = 16'(brv[i]);
            vtab[i].im_in   = 16'h0000;
            vtab[i].exp_re  = 16'(i);
            vtab[i].exp_idx = 12'(i);
        end
        set_nfft(4'd3);
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) begin
            e.re    = vtab[i].exp_re;
            e.im    = 16'h0000;
            e.idx   = vtab[i].exp_idx;
            e.edone = (vtab[i].exp_idx == 12'd6);
            e.done  = (vtab[i].exp_idx == 12'd7);
            sb.push_back(e);
        end
        for (int i = 0; i < 8; i++) send(vtab[i].re_in, vtab[i].im_in);
        in_dv = 1'b0;
        wait_drain("t1_drain");
        chk("t1_latency", 32'(first_dv_cyc - last_acc_cyc), 32'd1);
        chk("t1_done_count", 32'(done_cnt - d0), 32'd1);

        // Three back-to-back 16-point frames, continuous input
        set_nfft(4'd4);
        s0 = stall_total; r0 = rise_cnt; d0 = done_cnt;
        for (int f = 0; f < 3; f++) send_frame(4, -1, 4'd0, 0);
        wait_drain("t2_drain");
        chk("t2_rfd_stalls", 32'(stall_total - s0), 32'd0);
        chk("t2_dv_bursts",  32'(rise_cnt - r0),    32'd1);
        chk("t2_done_count", 32'(done_cnt - d0),    32'd3);

        // Size change mid-frame, then clamping of out-of-range sizes
        set_nfft(4'd3);
        d0 = done_cnt;
        send_frame(3, 3, 4'd5, 0);
        send_frame(5, -1, 4'd0, 0);
        wait_drain("t3_drain_8_32");
        set_nfft(4'd1);
        send_frame(3, -1, 4'd0, 0);
        wait_drain("t3_drain_clamp_lo");
        set_nfft(4'd15);
        send_frame(12, -1, 4'd0, 0);
        wait_drain("t3_drain_clamp_hi");
        chk("t3_done_count", 32'(done_cnt - d0), 32'd4);

        // 32-point frame draining while an 8-point frame fills the other bank;
        // the third frame must stall until the first bank is empty.
        set_nfft(4'd5);
        s0 = stall_total;
        send_frame(5, 10, 4'd3, 0);
        send_frame(3, -1, 4'd0, 0);
        send_frame(3, -1, 4'd0, 0);
        chk("t4_stall_cycles", 32'(stall_total - s0), 32'd24);
        wait_drain("t4_drain");
`ifdef FFT_REORDER_DROP_CNT_EN
        exp_drop = stall_total;
`else
        exp_drop = 0;
`endif
        chk("t4_drop_cnt", 32'(drop_cnt), 32'(exp_drop));

        // Reset after 5 of 8 inputs discards the partial frame
        set_nfft(4'd3);
        for (int k = 0; k < 5; k++) send(16'(16'h1000 + k), 16'h0055);
        in_dv = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_values("midrst");
        rst = 1'b0;
        @(posedge clk); #1;
        set_nfft(4'd3);
        d0 = done_cnt;
        send_frame(3, -1, 4'd0, 1);
        wait_drain("t5_drain");
        chk("t5_done_count", 32'(done_cnt - d0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Parametrised ping-pong reorder buffer that sits behind the pipelined FFT cores.
- Accepts frames in bit-reversed order and emits them in natural order.
- Output uses the FFT core's result interface: dv, xk_re/xk_im, xk_index, done, edone.
- Point size is set at run time per frame, so one instance serves 8- to 2^MAX_LOG2N-point transforms.

Parameters:
- DATA_W, 16: width of each real and imaginary sample.
- MAX_LOG2N, 12: log2 of the largest frame. Each bank holds 2^MAX_LOG2N complex words.
- NW, $clog2(MAX_LOG2N+1): width of the nfft field. Derived; do not override.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- nfft  in  NW  log2 of the frame size.
- nfft_we  in  1  write strobe for nfft.
- in_dv  in  1  input sample valid.
- in_re  in  DATA_W  input real part.
- in_im  in  DATA_W  input imaginary part.
- rfd  out  1  ready for data; an input is accepted only when in_dv and rfd are both high.
- busy  out  1  read side is emitting a frame.
- dv  out  1  output valid.
- xk_re  out  DATA_W  output real part.
- xk_im  out  DATA_W  output imaginary part.
- xk_index  out  MAX_LOG2N  natural-order index of the current output sample.
- edone  out  1  pulse one cycle before done.
- done  out  1  pulse with the last sample of a frame.
- drop_cnt  out  16  count of rejected in_dv cycles (see Optional Feature).

Behaviour:
- Reset values: rfd=1, busy=0, dv=0, done=0, edone=0, xk_re=xk_im=xk_index=0, drop_cnt=0. Both banks marked empty, write bank = 0, nfft register = MAX_LOG2N.
- Reset mid-operation: any partial or pending frame is discarded.
- nfft handling:
  - nfft_we updates a shadow register. Values below 3 clamp to 3; values above MAX_LOG2N clamp to MAX_LOG2N.
  - The shadow value is latched into the write side only when the write count is 0, i.e. at a frame boundary.
  - That latched size travels with the bank, so the read side always uses the size the frame was written with.
- Write side:
  - The k-th accepted sample is written at address bitrev_L(k), where L is the frame's log2n: reverse the low L bits of k; the upper bits are 0.
  - After the (2^L)-th sample, the bank is marked full and the count resets to 0.
  - Writing then moves to the other bank if it is empty; otherwise rfd drops to 0.
  - rfd = 1 whenever the current write bank is empty.
- Read side, state machine with two states:
  - R_IDLE -> R_RUN when a bank is full, which can be the cycle after that bank's last write.
  - In R_RUN, read address a counts 0 .. 2^L-1, one per cycle. The RAM read takes one cycle, so dv/xk_* lag the address by one cycle; xk_index = a.
  - busy is high from the first address cycle through the cycle of done.
  - edone is asserted with xk_index = 2^L-2; done with xk_index = 2^L-1.
  - On the final address the bank is marked empty.
  - If the other bank is already full, the state stays R_RUN and output continues gap-free with that bank's address 0; otherwise -> R_IDLE.
- Latency: last input accepted in cycle t -> first dv in cycle t+2 (idle read side). Output throughput is 1 sample per cycle; there is no output backpressure.
- Simultaneous events:
  - A bank becoming empty (read) and the other becoming full (write) in the same cycle are both honoured.
  - rfd returns to 1 in the cycle after the empty event.
- RAM: two banks of 2^MAX_LOG2N x 2*DATA_W simple dual-port memory, written synchronously and read through a register.

Optional Feature:
- Macro: FFT_REORDER_DROP_CNT_EN.
- Defined: drop_cnt increments on every cycle with in_dv=1 and rfd=0. It saturates at 0xFFFF and clears only on rst.
- Undefined: drop_cnt is tied to 0 and no counter logic is built. Rejected samples are silently ignored in both cases.

Test Plan:
- nfft=3: feed im=0 and re = 0,4,2,6,1,5,3,7, which are the bit-reversed indices k, in consecutive cycles -> output re 0..7 with xk_index 0..7; edone on index 6, done on index 7; first dv 2 cycles after the last input.
- Three back-to-back nfft=4 frames with continuous in_dv -> rfd never drops, dv continuous across frames, one done per 16 outputs, all data correct.
- nfft=3 frame followed by nfft_we with nfft=5 during that frame -> first frame reorders as 8 points, next frame as 32 points; nfft=1 clamps to 8 points, nfft=15 clamps to 4096.
- Two full frames buffered while the read side is busy -> rfd=0 until the first bank drains. In_dv held high during rfd=0 -> drop_cnt equals the stall cycle count with the macro defined, 0 without it.
- rst asserted after 5 of 8 inputs -> all outputs at reset values next cycle; a fresh 8-sample frame then emerges correctly with no leftover data.
- DATA_W=16 extremes: re=0x8000, im=0x7FFF -> passed through bit-exact at the correct natural index.
